// File: rtl/enc_pkg.sv
// Shared constants for the 3x8 decoder / 8x3 encoder pair: index width and FSM encoding.
package enc_pkg;
  localparam int ONEHOT_W = 8;
  localparam int CODE_W   = $clog2(ONEHOT_W);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_SCAN = 1'b1;
endpackage

// File: rtl/prio_enc.sv
// Combinational priority encoder: index of the first set bit, plus any/single-bit flags.
module prio_enc #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CODE_W    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]  mask,
  output logic [CODE_W-1:0] code,
  output logic              any,
  output logic              single
);
  // Scan from the low-priority end so the winning bit is written last.
  always_comb begin
    code = '0;
    if (LSB_FIRST) begin
      for (int i = WIDTH - 1; i >= 0; i--)
        if (mask[i]) code = CODE_W'(i);
    end else begin
      for (int i = 0; i < WIDTH; i++)
        if (mask[i]) code = CODE_W'(i);
    end
  end

  assign any    = |mask;
  assign single = any && ((mask & (mask - WIDTH'(1))) == '0);
endmodule

// File: rtl/encoder_8x3_stream.sv
// Streaming 8-to-3 encoder: one output beat per set bit of each accepted mask word,
// in priority order, with the final beat flagged; all-zero words give one empty beat.
module encoder_8x3_stream
  import enc_pkg::*;
#(
  parameter int WIDTH     = ONEHOT_W,
  parameter int CODE_W    = $clog2(WIDTH),
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_last,
  output logic              out_empty
);
  logic              r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_mask;
  logic              r_empty;
  logic [CODE_W-1:0] w_code;
  logic              w_any, w_single;
  logic              w_in_xfer, w_out_xfer;

  prio_enc #(.WIDTH(WIDTH), .LSB_FIRST(LSB_FIRST), .CODE_W(CODE_W)) u_prio (
    .mask  (r_mask),
    .code  (w_code),
    .any   (w_any),
    .single(w_single)
  );

  assign w_out_xfer = out_valid && out_ready;
  assign w_in_xfer  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A new word accepted alongside the last beat keeps us in SCAN: no bubble.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_in_xfer) w_state_nxt = S_SCAN;
      S_SCAN:  if (w_out_xfer && out_last && !w_in_xfer) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (r_state == S_SCAN);
    out_empty = out_valid && r_empty;
    out_last  = out_valid && (r_empty || w_single);
    out_code  = (out_valid && w_any) ? w_code : '0;
    in_ready  = (r_state == S_IDLE) || (w_out_xfer && out_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask  <= '0;
      r_empty <= 1'b0;
    end else if (w_in_xfer) begin
      r_mask  <= in_data;
      r_empty <= (in_data == '0);
    end else if (w_out_xfer) begin
      r_mask  <= r_mask & ~(WIDTH'(1) << out_code);
      if (out_last) r_empty <= 1'b0;
    end
  end
endmodule
